// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t state, state_next;

  logic              accept;
  logic              special;
  logic [XLEN-1:0]   special_result;
  logic              a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [XLEN-1:0]   opd_q;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   acc_hi;   // product high half or partial remainder
  logic [XLEN-1:0]   acc_lo;   // multiplier (consumed LSB-first) or dividend/quotient
  logic [CNT_W-1:0]  count;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fixup_result;

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign done  = (state == S_DONE);

  // Operand conditioning and single-cycle special cases, evaluated on the raw inputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    a_neg_in       = 1'b0;
    b_neg_in       = 1'b0;
    special        = 1'b0;
    special_result = '0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_neg_in = a[XLEN-1];
        b_neg_in = b[XLEN-1];
      end
      OP_MULHSU: a_neg_in = a[XLEN-1];
      default: ;
    endcase
    a_mag = a_neg_in ? -a : a;
    b_mag = b_neg_in ? -b : b;

    if (op[2]) begin
      if (b == '0) begin
        special        = 1'b1;
        special_result = op[1] ? a : '1;
      end else if (!op[0] && a == MIN_NEG && b == '1) begin
        special        = 1'b1;
        special_result = op[1] ? '0 : a;
      end
    end
  end

  assign accept = start && ready && !kill;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = special ? S_DONE : S_CALC;
        else        state_next = S_IDLE;
      end
      S_CALC: begin
        if (kill)                              state_next = S_IDLE;
        else if (count == CNT_W'(XLEN - 1))    state_next = S_FIXUP;
      end
      S_FIXUP: state_next = kill ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Iteration arithmetic. A restoring step keeps the shifted remainder when the trial
  // subtraction borrows; the borrow shows up in the top bit of the XLEN+1-bit difference.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_q};

    prod     = {acc_hi, acc_lo};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quot_fix = (a_neg_q ^ b_neg_q) ? -acc_lo : acc_lo;
    rem_fix  = a_neg_q ? -acc_hi : acc_hi;

    case (op_q)
      OP_MUL:                       fixup_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixup_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixup_result = quot_fix;
      OP_REM, OP_REMU:              fixup_result = rem_fix;
      default:                      fixup_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= OP_MUL;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      opd_q   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      opd_q   <= b_mag;
      acc_hi  <= '0;
      acc_lo  <= a_mag;
      count   <= '0;
      if (special) result <= special_result;
    end else if (state == S_CALC && !kill) begin
      count <= count + 1'b1;
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          acc_hi <= div_diff[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[XLEN:1];
        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
      end
    end else if (state == S_FIXUP && !kill) begin
      result <= fixup_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake/kill/reset
// scenarios and randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int NORMAL_LAT = XLEN + 1;  // edges after the accept edge until done is seen

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            kill = 1'b0;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = 64'(sx / sy); return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sx % sy); return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 3'd4) return 1'b0;
    if (y == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  // Called right after the accept edge (at its negedge); counts further edges until done.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    wait_done(lat);
    res = result;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b result=%h, required ready=1 done=0 result=0", ready, done, result);
    end
    reset = 1'b1;
  endtask

  task automatic test_mul_basic;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd4; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_ready_drop: ready=%b, required 0", ready);
    end
    wait_done(lat);
    n_checks++;
    if (lat + 1 !== XLEN + 2 || result !== 32'd8 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_4x2: latency=%0d result=%h ready=%b, required latency=%0d result=8 ready=1",
               lat + 1, result, ready, XLEN + 2);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== 32'd8) begin
      n_fail++;
      $display("FAIL done_single_pulse: done=%b result=%h, required done=0 result=8", done, result);
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[11];
    logic [31:0] res;
    int lat;
    v[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORMAL_LAT};
    v[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_LAT};
    v[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORMAL_LAT};
    v[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORMAL_LAT};
    v[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORMAL_LAT};
    v[5]  = '{3'd5, 32'd3006,      32'd3,         32'd1002,      NORMAL_LAT};
    v[6]  = '{3'd4, 32'd3012,      32'd0,         32'hFFFF_FFFF, 0};
    v[7]  = '{3'd7, 32'd3012,      32'd0,         32'd3012,      0};
    v[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    v[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    v[10] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, NORMAL_LAT};
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].o, v[i].x, v[i].y, res, lat);
      n_checks++;
      if (res !== v[i].exp || lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h: result=%h latency=%0d, required result=%h latency=%0d",
                 i, v[i].o, v[i].x, v[i].y, res, lat, v[i].exp, v[i].lat);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3005; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 9) begin start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd5; end
      else start = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (result !== 32'd6010 || lat !== NORMAL_LAT) begin
      n_fail++;
      $display("FAIL ignore_start: result=%0d latency=%0d, required result=6010 latency=%0d", result, lat, NORMAL_LAT);
    end
    start = 1'b1; op = 3'd7; a = 32'd10; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_accept: ready=%b done=%b, required ready=0 done=0", ready, done);
    end
    wait_done(lat);
    n_checks++;
    if (result !== 32'd1 || lat !== NORMAL_LAT) begin
      n_fail++;
      $display("FAIL back_to_back_remu: result=%0d latency=%0d, required result=1 latency=%0d", result, lat, NORMAL_LAT);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== '0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_div: done=%b result=%h ready=%b, required done=0 result=0 ready=1", done, result, ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_kill;
    logic [31:0] res;
    int lat;
    int seen;
    run_op(3'd0, 32'd7, 32'd6, res, lat);
    n_checks++;
    if (res !== 32'd42) begin
      n_fail++;
      $display("FAIL kill_setup: result=%0d, required 42", res);
    end
    // Kill at cycle 20 of a MUL, then kill while in FIXUP.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat ((k == 0) ? 19 : 32) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL kill_ready_%0d: ready=%b, required 1", k, ready);
      end
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      n_checks++;
      if (seen !== 0 || result !== 32'd42) begin
        n_fail++;
        $display("FAIL kill_no_done_%0d: done pulses=%0d result=%0d, required 0 pulses result=42", k, seen, result);
      end
    end
    // kill overrides a simultaneous start while idle
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_over_start: ready=%b done=%b, required ready=1 done=0", ready, done);
    end
    run_op(3'd0, 32'd5, 32'd5, res, lat);
    n_checks++;
    if (res !== 32'd25 || lat !== NORMAL_LAT) begin
      n_fail++;
      $display("FAIL after_kill: result=%0d latency=%0d, required result=25 latency=%0d", res, lat, NORMAL_LAT);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y, res, exp;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      exp = model(o, x, y);
      exp_lat = is_special(o, x, y) ? 0 : NORMAL_LAT;
      run_op(o, x, y, res, lat);
      n_checks++;
      if (res !== exp || lat !== exp_lat) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h latency=%0d, required result=%h latency=%0d",
                 i, o, x, y, res, lat, exp, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_directed();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_kill();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
